// File: rtl/button_direction_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_direction_conditioner: sync + debounce four buttons, derive a      |
// | press pulse per button and a prioritised 2-bit direction code.            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module button_direction_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       left_pulse,
  output logic       right_pulse,
  output logic [1:0] dir_code,
  output logic       dir_strobe
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_wait_pr = 2'd1;
  localparam logic [1:0] c_pressed = 2'd2;
  localparam logic [1:0] c_wait_rl = 2'd3;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  // Channel index doubles as the direction code: 0 right, 1 left, 2 up, 3 down.
  logic [3:0] w_raw;
  logic [3:0] w_level;
  logic [3:0] w_pulse;

  assign w_raw = {btn_down_raw, btn_up_raw, btn_left_raw, btn_right_raw};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_chan
      logic             r_s1;
      logic             r_s2;
      logic [1:0]       r_state;
      logic [CNT_W-1:0] r_cnt;
      logic             r_level;
      logic             r_pulse;

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_state <= c_idle;
          r_cnt   <= '0;
          r_level <= 1'b0;
          r_pulse <= 1'b0;
        end else begin
          r_s1    <= w_raw[i];
          r_s2    <= r_s1;
          r_pulse <= 1'b0;
          case (r_state)
            c_idle: begin
              if (r_s2) begin
                r_state <= c_wait_pr;
                r_cnt   <= '0;
              end
            end
            c_wait_pr: begin
              if (!r_s2) begin
                r_state <= c_idle;
              end else if (r_cnt == c_cnt_last) begin
                r_state <= c_pressed;
                r_level <= 1'b1;
                r_pulse <= 1'b1;
              end else begin
                r_cnt <= r_cnt + c_cnt_one;
              end
            end
            c_pressed: begin
              if (!r_s2) begin
                r_state <= c_wait_rl;
                r_cnt   <= '0;
              end
            end
            c_wait_rl: begin
              // A bounce back high resumes the press without a second pulse.
              if (r_s2) begin
                r_state <= c_pressed;
              end else if (r_cnt == c_cnt_last) begin
                r_state <= c_idle;
                r_level <= 1'b0;
              end else begin
                r_cnt <= r_cnt + c_cnt_one;
              end
            end
            default: begin
              r_state <= c_idle;
              r_level <= 1'b0;
            end
          endcase
        end
      end

      assign w_level[i] = r_level;
      assign w_pulse[i] = r_pulse;
    end
  endgenerate

  logic [1:0] w_code;

  always_comb begin
    w_code = 2'd0;
    if (w_pulse[0])      w_code = 2'd0;
    else if (w_pulse[1]) w_code = 2'd1;
    else if (w_pulse[2]) w_code = 2'd2;
    else if (w_pulse[3]) w_code = 2'd3;
  end

  logic [1:0] r_dir_code;
  logic       r_dir_strobe;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dir_code   <= 2'd0;
      r_dir_strobe <= 1'b0;
    end else begin
      r_dir_strobe <= |w_pulse;
      if (|w_pulse) begin
        r_dir_code <= w_code;
      end
    end
  end

  assign right       = w_level[0];
  assign left        = w_level[1];
  assign up          = w_level[2];
  assign down        = w_level[3];
  assign right_pulse = w_pulse[0];
  assign left_pulse  = w_pulse[1];
  assign up_pulse    = w_pulse[2];
  assign down_pulse  = w_pulse[3];
  assign dir_code    = r_dir_code;
  assign dir_strobe  = r_dir_strobe;

endmodule
`default_nettype wire

// File: tb/tb_button_direction_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_button_direction_conditioner: directed and random checks of the button |
// | conditioner against a stable-run-length reference model.                  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_button_direction_conditioner;

  localparam int DC = 4;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
  logic       up, down, left, right;
  logic       up_pulse, down_pulse, left_pulse, right_pulse;
  logic [1:0] dir_code;
  logic       dir_strobe;

  button_direction_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up_raw   (bu),
    .btn_down_raw (bd),
    .btn_left_raw (bl),
    .btn_right_raw(br),
    .up           (up),
    .down         (down),
    .left         (left),
    .right        (right),
    .up_pulse     (up_pulse),
    .down_pulse   (down_pulse),
    .left_pulse   (left_pulse),
    .right_pulse  (right_pulse),
    .dir_code     (dir_code),
    .dir_strobe   (dir_strobe)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: the accepted level flips once the synchronised input has disagreed
  // with it for DC+1 consecutive clock edges.
  bit       m_s1[4], m_s2[4], m_lvl[4], m_pul[4];
  int       m_run[4];
  bit [1:0] m_code;
  bit       m_strobe;

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_pul[i] = 0; m_run[i] = 0;
    end
    m_code = 0; m_strobe = 0;
    forever begin
      logic [3:0] raw;
      @(posedge clk);
      raw = {bd, bu, bl, br};
      if (!rst) begin
        for (int i = 0; i < 4; i++) begin
          m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_pul[i] = 0; m_run[i] = 0;
        end
        m_code = 0; m_strobe = 0;
      end else begin
        m_strobe = m_pul[0] | m_pul[1] | m_pul[2] | m_pul[3];
        for (int i = 3; i >= 0; i--)
          if (m_pul[i]) m_code = 2'(i);
        for (int i = 0; i < 4; i++) begin
          m_pul[i] = 0;
          if (m_s2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DC + 1) begin
              m_lvl[i] = m_s2[i];
              m_pul[i] = m_s2[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
          m_s2[i] = m_s1[i];
          m_s1[i] = raw[i];
        end
      end
    end
  end

  initial begin
    forever begin
      logic [10:0] act, exp;
      @(negedge clk);
      act = {down, up, left, right, down_pulse, up_pulse, left_pulse, right_pulse,
             dir_code, dir_strobe};
      exp = {m_lvl[3], m_lvl[2], m_lvl[1], m_lvl[0], m_pul[3], m_pul[2], m_pul[1],
             m_pul[0], m_code, m_strobe};
      n_assert++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model_cmp at %0t: got %b expected %b (lvl[dulr] pul[dulr] code strobe)",
                 $time, act, exp);
      end
    end
  end

  int pcnt[4] = '{0, 0, 0, 0};
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (right_pulse) pcnt[0]++;
      if (left_pulse)  pcnt[1]++;
      if (up_pulse)    pcnt[2]++;
      if (down_pulse)  pcnt[3]++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p;
    step(3);
    chk("reset_outputs", int'({up, down, left, right, up_pulse, down_pulse,
                               left_pulse, right_pulse, dir_code, dir_strobe}), 0);
    rst = 1'b1;
    step(2);

    // Clean press of up
    bu = 1'b1;
    step(6);
    chk("clean_up_before_e7", int'(up), 0);
    chk("clean_up_pulse_before_e7", int'(up_pulse), 0);
    step(1);
    chk("clean_up_pulse_e7", int'(up_pulse), 1);
    chk("clean_up_level_e7", int'(up), 1);
    chk("clean_strobe_e7", int'(dir_strobe), 0);
    step(1);
    chk("clean_up_pulse_e8", int'(up_pulse), 0);
    chk("clean_strobe_e8", int'(dir_strobe), 1);
    chk("clean_code_e8", int'(dir_code), 2);
    step(1);
    chk("clean_strobe_e9", int'(dir_strobe), 0);
    step(11);
    bu = 1'b0;
    step(6);
    chk("clean_up_release_e6", int'(up), 1);
    step(1);
    chk("clean_up_release_e7", int'(up), 0);
    step(4);

    // Bounce on right, then a clean hold
    p = pcnt[0];
    repeat (3) begin
      br = 1'b1; step(2);
      br = 1'b0; step(2);
    end
    chk("bounce_right_level", int'(right), 0);
    chk("bounce_right_pulses", pcnt[0] - p, 0);
    br = 1'b1;
    step(6);
    chk("bounce_hold_pulse_e6", int'(right_pulse), 0);
    step(1);
    chk("bounce_hold_pulse_e7", int'(right_pulse), 1);
    step(3);
    br = 1'b0;
    step(10);

    // Release glitch on left
    bl = 1'b1;
    step(10);
    chk("glitch_left_pressed", int'(left), 1);
    p = pcnt[1];
    bl = 1'b0; step(2);
    bl = 1'b1; step(10);
    chk("glitch_left_held", int'(left), 1);
    chk("glitch_left_no_pulse", pcnt[1] - p, 0);
    bl = 1'b0;
    step(6);
    chk("glitch_left_drop_e6", int'(left), 1);
    step(1);
    chk("glitch_left_drop_e7", int'(left), 0);
    step(4);

    // Simultaneous right + up
    br = 1'b1; bu = 1'b1;
    step(7);
    chk("simul_right_pulse", int'(right_pulse), 1);
    chk("simul_up_pulse", int'(up_pulse), 1);
    step(1);
    chk("simul_strobe", int'(dir_strobe), 1);
    chk("simul_code", int'(dir_code), 0);
    step(1);
    chk("simul_single_strobe", int'(dir_strobe), 0);
    br = 1'b0; bu = 1'b0;
    step(12);

    // Long hold on down
    p = pcnt[3];
    bd = 1'b1;
    step(1000);
    chk("hold_down_one_pulse", pcnt[3] - p, 1);
    chk("hold_down_code", int'(dir_code), 3);
    chk("hold_down_level", int'(down), 1);
    bd = 1'b0;
    step(12);

    // Reset in the middle of the press count
    bu = 1'b1;
    step(4);
    rst = 1'b0;
    step(1);
    chk("midreset_outputs", int'({up, down, left, right, up_pulse, down_pulse,
                                  left_pulse, right_pulse, dir_code, dir_strobe}), 0);
    rst = 1'b1;
    step(6);
    chk("midreset_up_e6", int'(up), 0);
    step(1);
    chk("midreset_pulse_e7", int'(up_pulse), 1);
    step(1);
    chk("midreset_code_e8", int'(dir_code), 2);
    bu = 1'b0;
    step(12);

    // Random stimulus checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 9) == 0)  br = ~br;
      if ($urandom_range(0, 7) == 0)  bl = ~bl;
      if ($urandom_range(0, 11) == 0) bu = ~bu;
      if ($urandom_range(0, 5) == 0)  bd = ~bd;
      step(1);
    end
    rst = 1'b1; br = 1'b0; bl = 1'b0; bu = 1'b0; bd = 1'b0;
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
